fifo_serial_tx: RTL and testbench
=================================

# fifo_serial_tx

Drain-side consumer for the 8-bit, 16-deep FIFO: it watches the FIFO's empty flag, issues single-cycle read enables, and captures the show-ahead read data. It then shifts each byte out as an asynchronous serial frame: start bit, 8 data bits LSB first, optional parity bit, stop bit. It sits between the FIFO's read port and the chip's serial TX pin, and is the read-side counterpart of the block that writes into the FIFO.

## Interface
- CLKS_PER_BIT, 16: clock cycles per serial bit; legal range 2..65535.
- DATA_W, 8: data bits per frame; fixed at 8 to match FIFO width.
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- fifo_empty  input  1  FIFO empty flag.
- data_in  input  8  FIFO read data; combinational from read pointer, valid whenever fifo_empty=0.
- rdEn  output  1  FIFO read enable; pops one byte on the rising edge where it is high.
- tx_en  input  1  permits new frames; does not abort a frame in progress.
- tx  output  1  serial line; idle high.
- busy  output  1  high from the first start-bit cycle through the last stop-bit cycle.
- frame_done  output  1  one-cycle pulse in the last stop-bit cycle.

## Operation
- States:
  - IDLE: line high, waiting for data.
  - START: drives start bit 0.
  - DATA: drives 8 bits, LSB first.
  - PARITY: present only with macro.
  - STOP: drives stop bit 1.
- rdEn is combinational: rdEn = reset & tx_en & ~fifo_empty & (state==IDLE).
- On the edge where rdEn=1:
  - data_in is loaded into the 8-bit shift register.
  - state moves IDLE->START.
  - bit timer clears to 0.
- Bit timer counts 0..CLKS_PER_BIT-1. It is $clog2(CLKS_PER_BIT) bits wide and wraps to 0 at terminal count.
- At each terminal count:
  - START->DATA.
  - DATA shifts the register right. After the 8th bit: DATA->PARITY (macro) or STOP.
  - PARITY->STOP.
  - STOP->IDLE.
- Data bit index is a 3-bit counter that wraps 7->0 on exit from DATA.
- tx is registered and driven from state and shift register bit 0. The line never glitches within a bit.
- Boundary conditions:
  - fifo_empty changes mid-frame: ignored.
  - tx_en falls mid-frame: current frame completes; no further rdEn.
  - Back-to-back: STOP->IDLE, then rdEn in that IDLE cycle if data is present. This yields exactly one extra idle-high cycle between frames.
  - reset asserted mid-frame: immediately tx=1, busy=0, frame_done=0, state=IDLE. The captured byte is discarded; the FIFO pop has already occurred.

## Timing
- Reset values: tx=1, busy=0, frame_done=0, rdEn=0, state=IDLE, timer=0, shift register=0.
- Cycle 0 is the rdEn cycle:
  - start bit occupies cycles 1..N, where N=CLKS_PER_BIT.
  - data bit k occupies cycles (k+1)N+1..(k+2)N.
  - stop bit occupies cycles 9N+1..10N.
  - frame_done is high in cycle 10N.
  - Next rdEn is possible at cycle 10N+1.
- With parity, the parity bit occupies 9N+1..10N, the stop bit occupies 10N+1..11N, and frame_done is high in cycle 11N.
- Throughput: one byte per 10N+1 cycles (11N+1 with parity).

## Configuration
- FIFO_SERIAL_TX_PARITY_EN:
  - Defined: PARITY state is compiled in, and one even-parity bit (XOR of the 8 data bits) is sent between the data and stop bits.
  - Undefined: no parity state or logic; frames are 10 bits.

## Structure
- Package fifo_serial_tx_pkg holds:
  - state enum (IDLE, START, DATA, PARITY, STOP);
  - constants START_BIT=1'b0, STOP_BIT=1'b1, IDLE_LEVEL=1'b1, DATA_BITS=8.
- Sub-module tx_bit_timer:
  - parameterised by CLKS_PER_BIT;
  - inputs clk, reset, clear;
  - output tick, high on terminal count.

## Test plan
- Reset: hold reset=0 with fifo_empty=0 -> tx=1, busy=0, rdEn=0, frame_done=0 throughout.
- Single byte, N=4, 0xA5 in FIFO, tx_en=1 -> rdEn high one cycle. tx is 0 for cycles 1-4, then data bits 1,0,1,0,0,1,0,1 at 4 cycles each, then 1 for cycles 37-40. frame_done fires at cycle 40, then fifo_empty=1 and the line stays high.
- Back-to-back 0x00 then 0xFF, N=4 -> second rdEn at cycle 41, second start bit at cycles 42-45, 0xFF data bits all 1 at cycles 46-77.
- Reset mid-frame: assert reset at cycle 20 of a 0x3C frame -> tx=1 and busy=0 within the same cycle. After release with fifo_empty=1, no rdEn occurs.
- tx_en gating:
  - tx_en=0 with fifo_empty=0 for 50 cycles -> rdEn=0, tx=1.
  - Drop tx_en at cycle 10 of a frame -> frame completes normally and no second read occurs.
- Parity (macro defined), N=4, byte 0x07 -> parity bit 1 at cycles 37-40, stop bit at cycles 41-44, frame_done at cycle 44.

Source files
------------

// File: rtl/fifo_serial_tx_pkg.sv
// Shared types and line-level constants for the FIFO-drain serial transmitter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package fifo_serial_tx_pkg;

    // Frame sequencer states; PARITY is only reachable when the parity build option is on
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;
    localparam int   DATA_BITS  = 8;

    // Even parity: the bit that makes the total count of ones even
    function automatic logic even_parity(input logic [DATA_BITS-1:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/tx_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the terminal count.
// Latency: tick is combinational from the count; count updates every clk.
// Backpressure: none; clear holds the count at zero.
module tx_bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == TERMINAL);

    // Free-running bit counter, wrapped at terminal count and held at zero while cleared
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/fifo_serial_tx.sv
// Pops bytes from a show-ahead FIFO and sends them as start/8 data LSB-first/stop frames
// (plus even parity when FIFO_SERIAL_TX_PARITY_EN is defined). Latency: start bit one cycle after rdEn.
// Backpressure: reads only from IDLE with tx_en high; a frame in flight always finishes.
module fifo_serial_tx
    import fifo_serial_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_W       = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] data_in,
    output logic              rdEn,
    input  logic              tx_en,
    output logic              tx,
    output logic              busy,
    output logic              frame_done
);

    tx_state_t         state, state_nxt;
    logic [DATA_W-1:0] shift_q, shift_nxt;
    logic [2:0]        bit_idx_q, bit_idx_nxt;
    logic              tx_q, tx_nxt;
    logic              tick;
    logic              rd_go;
`ifdef FIFO_SERIAL_TX_PARITY_EN
    logic              parity_q;
`endif

    // A pop happens only from IDLE; reset is folded in so no read can leak out during reset
    assign rd_go = reset & tx_en & ~fifo_empty & (state == IDLE);
    assign rdEn  = rd_go;

    // Timer is held at zero in IDLE so each start bit gets a full period from the load edge
    tx_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk   (clk),
        .reset (reset),
        .clear (state == IDLE),
        .tick  (tick)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: every non-idle state lasts exactly one bit period
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (rd_go) state_nxt = START;
            START:  if (tick)  state_nxt = DATA;
            DATA: begin
                if (tick && (bit_idx_q == 3'(DATA_BITS - 1))) begin
`ifdef FIFO_SERIAL_TX_PARITY_EN
                    state_nxt = PARITY;
`else
                    state_nxt = STOP;
`endif
                end
            end
`ifdef FIFO_SERIAL_TX_PARITY_EN
            PARITY: if (tick)  state_nxt = STOP;
`endif
            STOP:   if (tick)  state_nxt = IDLE;
            default:           state_nxt = IDLE;
        endcase
    end

    // Datapath next values: load on pop, shift right at the end of each data bit
    always_comb begin
        shift_nxt   = shift_q;
        bit_idx_nxt = bit_idx_q;
        if (rd_go) begin
            shift_nxt = data_in;
        end else if ((state == DATA) && tick) begin
            shift_nxt   = {1'b0, shift_q[DATA_W-1:1]};
            bit_idx_nxt = bit_idx_q + 3'd1;
        end
    end

    // Line level for the coming cycle, derived from next state so tx lines up with the state
    always_comb begin
        tx_nxt = IDLE_LEVEL;
        case (state_nxt)
            START:  tx_nxt = START_BIT;
            DATA:   tx_nxt = shift_nxt[0];
`ifdef FIFO_SERIAL_TX_PARITY_EN
            PARITY: tx_nxt = parity_q;
`endif
            STOP:   tx_nxt = STOP_BIT;
            default: tx_nxt = IDLE_LEVEL;
        endcase
    end

    assign busy       = (state != IDLE);
    assign frame_done = (state == STOP) && tick;
    assign tx         = tx_q;

    // Datapath and registered line driver; reset forces the line idle at once
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_q   <= '0;
            bit_idx_q <= '0;
            tx_q      <= IDLE_LEVEL;
        end else begin
            shift_q   <= shift_nxt;
            bit_idx_q <= bit_idx_nxt;
            tx_q      <= tx_nxt;
        end
    end

`ifdef FIFO_SERIAL_TX_PARITY_EN
    // Parity is taken from the byte as popped, before the shifter consumes it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            parity_q <= 1'b0;
        end else if (rd_go) begin
            parity_q <= even_parity(data_in);
        end
    end
`endif

endmodule

// File: tb/tb_fifo_serial_tx.sv
module tb_fifo_serial_tx;

    localparam int N = 4;
`ifdef FIFO_SERIAL_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       fifo_empty = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       tx_en = 1'b0;
    logic       rdEn;
    logic       tx;
    logic       busy;
    logic       frame_done;

    logic [7:0] fq[$];
    logic       rd_at_edge;
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    fifo_serial_tx #(
        .CLKS_PER_BIT (N),
        .DATA_W       (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .fifo_empty (fifo_empty),
        .data_in    (data_in),
        .rdEn       (rdEn),
        .tx_en      (tx_en),
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", tag, act, exp, $time);
        end
    endtask

    // Show-ahead FIFO model: head of queue is visible whenever non-empty
    task automatic fifo_sync();
        fifo_empty = (fq.size() == 0);
        data_in    = fifo_empty ? 8'h00 : fq[0];
    endtask

    // One clock: note rdEn before the edge, pop after it, settle outputs
    task automatic step();
        logic [7:0] tmp;
        @(negedge clk);
        rd_at_edge = rdEn;
        @(posedge clk);
        #1;
        if (rd_at_edge && fq.size() > 0) begin
            tmp = fq.pop_front();
            fifo_sync();
        end
        #1;
    endtask

    // Expected line level c cycles after the rdEn cycle
    function automatic logic exp_tx(input logic [7:0] b, input int c);
        int slot;
        slot = (c - 1) / N;
        if (slot == 0)                    return 1'b0;
        else if (slot <= 8)               return b[slot-1];
        else if (FB == 11 && slot == 9)   return ^b;
        else                              return 1'b1;
    endfunction

    task automatic wait_rd(input string tag);
        logic found;
        found = 1'b0;
        #1;
        for (int i = 0; i < 40; i++) begin
            if (rdEn) begin
                found = 1'b1;
                break;
            end
            step();
        end
        chk(tag, found, 1'b1);
    endtask

    // Called in the rdEn cycle; walks the whole frame cycle by cycle
    task automatic check_frame(input logic [7:0] b, input int drop_at);
        for (int c = 1; c <= FB * N; c++) begin
            step();
            chk($sformatf("tx_%02h_c%0d", b, c), tx, exp_tx(b, c));
            chk($sformatf("busy_%02h_c%0d", b, c), busy, 1'b1);
            chk($sformatf("fdone_%02h_c%0d", b, c), frame_done, (c == FB * N));
            chk($sformatf("rden_%02h_c%0d", b, c), rdEn, 1'b0);
            if (c == drop_at) tx_en = 1'b0;
        end
    endtask

    task automatic idle_check(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            step();
            chk({tag, "_tx"}, tx, 1'b1);
            chk({tag, "_busy"}, busy, 1'b0);
            chk({tag, "_rden"}, rdEn, 1'b0);
            chk({tag, "_fdone"}, frame_done, 1'b0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with data present and tx_en high
        fq.push_back(8'h11);
        fifo_sync();
        tx_en = 1'b1;
        #1;
        chk("rst_rden0", rdEn, 1'b0);
        idle_check("rst", 5);
        fq.delete();
        fifo_sync();
        reset = 1'b1;

        // tx_en low blocks reads
        tx_en = 1'b0;
        fq.push_back(8'hA5);
        fifo_sync();
        idle_check("txen0", 50);

        // Single byte 0xA5
        tx_en = 1'b1;
        wait_rd("rd_a5");
        check_frame(8'hA5, 0);
        idle_check("post_a5", 5);
        chk("a5_popped", fq.size(), 0);

        // Back-to-back 0x00 then 0xFF
        fq.push_back(8'h00);
        fq.push_back(8'hFF);
        fifo_sync();
        wait_rd("rd_00");
        check_frame(8'h00, 0);
        step();
        chk("b2b_rden", rdEn, 1'b1);
        chk("b2b_tx", tx, 1'b1);
        chk("b2b_busy", busy, 1'b0);
        check_frame(8'hFF, 0);
        idle_check("post_ff", 3);

        // Reset mid-frame at cycle 20 of 0x3C
        fq.push_back(8'h3C);
        fifo_sync();
        wait_rd("rd_3c");
        for (int c = 1; c <= 20; c++) step();
        chk("mid_tx_c20", tx, 1'b1);
        chk("mid_busy_c20", busy, 1'b1);
        reset = 1'b0;
        #1;
        chk("mid_rst_tx", tx, 1'b1);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_fdone", frame_done, 1'b0);
        chk("mid_rst_rden", rdEn, 1'b0);
        step();
        step();
        reset = 1'b1;
        idle_check("post_rst", 10);

        // tx_en dropped at cycle 10: frame completes, no second read
        fq.push_back(8'h5A);
        fq.push_back(8'h66);
        fifo_sync();
        wait_rd("rd_5a");
        check_frame(8'h5A, 10);
        idle_check("txen_drop", 15);
        chk("txen_drop_left", fq.size(), 1);
        fq.delete();
        fifo_sync();

`ifdef FIFO_SERIAL_TX_PARITY_EN
        // Parity frame: 0x07 has three ones so parity bit is 1
        tx_en = 1'b1;
        fq.push_back(8'h07);
        fifo_sync();
        wait_rd("rd_07");
        check_frame(8'h07, 0);
        idle_check("post_07", 3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
